// File: rtl/fb_pkg.sv
// Framebuffer shared definitions: clear-sequencer states and default geometry.
package fb_pkg;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;
   localparam int FB_FILL   = 254;
   localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

   // Clear sequencer states
   // state | meaning
   // IDLE  | user writes accepted, waiting for clr_req
   // CLEAR | filling every word with clr_value_q, one word per cycle
   // DONE  | one-cycle completion pulse, user writes accepted
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_mem_core.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-first on a same-address collision; array is deliberately unreset.
module fb_mem_core #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 307200,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write and read in one block; non-blocking update gives old data on collision.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuffer_dp.sv
// Dual-port framebuffer with hardware clear sequencer.
// Optional macro FB_READ_REG_EN adds an output register (read latency 2).
module framebuffer_dp
   import fb_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = FB_DEPTH,
   parameter int ADDR_W       = 19,
   parameter int FILL_DEFAULT = FB_FILL
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              re,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   input  logic              clr_req,
   input  logic [DATA_W-1:0] clr_value,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_drop
);

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] FILL_VAL  = DATA_W'(FILL_DEFAULT);

   fb_state_e         state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [DATA_W-1:0] clr_value_q;
   logic              clr_busy_q;
   logic              clr_done_q;
   logic              wr_drop_q;
   logic              rd_valid1_q;
   logic              rd_zero_q;

   logic              in_clear;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              user_wr;
   logic              wr_drop_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_waddr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              mem_re_d;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] rd_data1;

   assign in_clear    = (state_q == CLEAR);
   assign wr_in_range = ({1'b0, write_addr} < DEPTH_X);
   assign rd_in_range = ({1'b0, read_addr} < DEPTH_X);

   // Write port steering: the clear sequencer owns the port while in CLEAR.
   always_comb begin
      user_wr     = we & wr_in_range & ~in_clear;
      wr_drop_d   = we & (in_clear | ~wr_in_range);
      mem_we_d    = in_clear | user_wr;
      mem_waddr_d = in_clear ? clr_cnt_q   : write_addr;
      mem_wdata_d = in_clear ? clr_value_q : data_in;
      mem_re_d    = re & rd_in_range;
   end

   // Clear sequencer: counter stops at the last address so it never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         clr_cnt_q   <= '0;
         clr_value_q <= FILL_VAL;
         clr_busy_q  <= 1'b0;
         clr_done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               clr_done_q <= 1'b0;
               if (clr_req) begin
                  state_q     <= CLEAR;
                  clr_cnt_q   <= '0;
                  clr_value_q <= clr_value;
                  clr_busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_q    <= DONE;
                  clr_busy_q <= 1'b0;
                  clr_done_q <= 1'b1;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q    <= IDLE;
               clr_done_q <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Drop pulse and first read stage; rd_zero_q forces 0 after reset or an out-of-range read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_drop_q   <= 1'b0;
         rd_valid1_q <= 1'b0;
         rd_zero_q   <= 1'b1;
      end else begin
         wr_drop_q   <= wr_drop_d;
         rd_valid1_q <= re;
         if (re) begin
            rd_zero_q <= ~rd_in_range;
         end
      end
   end

   fb_mem_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we_d),
      .waddr_i (mem_waddr_d),
      .wdata_i (mem_wdata_d),
      .re_i    (mem_re_d),
      .raddr_i (read_addr),
      .rdata_o (mem_rdata)
   );

   // RAM output only changes on an in-range read, so this holds when re=0.
   assign rd_data1 = rd_zero_q ? '0 : mem_rdata;

`ifdef FB_READ_REG_EN
   logic [DATA_W-1:0] data_out_q;
   logic              rd_valid2_q;

   // Output register stage, loaded only when stage one carries a fresh read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_q  <= '0;
         rd_valid2_q <= 1'b0;
      end else begin
         rd_valid2_q <= rd_valid1_q;
         if (rd_valid1_q) begin
            data_out_q <= rd_data1;
         end
      end
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid2_q;
`else
   assign data_out = rd_data1;
   assign rd_valid = rd_valid1_q;
`endif

   assign clr_busy = clr_busy_q;
   assign clr_done = clr_done_q;
   assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_framebuffer_dp.sv
// Randomized self-checking bench for framebuffer_dp against a behavioural model.
module tb_framebuffer_dp;

   localparam int DW    = 8;
   localparam int DEPTH = 200;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          we, re, clr_req;
   logic [AW-1:0] write_addr, read_addr;
   logic [DW-1:0] data_in, clr_value, data_out;
   logic          rd_valid, clr_busy, clr_done, wr_drop;

   always #5 clk = ~clk;

   framebuffer_dp #(
      .DATA_W       (DW),
      .DEPTH        (DEPTH),
      .ADDR_W       (AW),
      .FILL_DEFAULT (254)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .write_addr (write_addr),
      .data_in    (data_in),
      .re         (re),
      .read_addr  (read_addr),
      .data_out   (data_out),
      .rd_valid   (rd_valid),
      .clr_req    (clr_req),
      .clr_value  (clr_value),
      .clr_busy   (clr_busy),
      .clr_done   (clr_done),
      .wr_drop    (wr_drop)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int busy_seen, done_seen;

   // Behavioural model: memory image plus "words still to clear" count.
   logic [DW-1:0] m_mem   [DEPTH];
   bit            m_known [DEPTH];
   int            m_left;
   bit            m_done;
   bit            m_drop;
   logic [DW-1:0] m_cval;
   bit            s1_v, s1_k, p2_v, p2_k;
   logic [DW-1:0] s1_d, p2_d;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      m_left = 0; m_done = 0; m_drop = 0;
      s1_v = 0; s1_d = '0; s1_k = 1;
      p2_v = 0; p2_d = '0; p2_k = 1;
   endtask

   task automatic model_step();
      bit was_clear, was_done;
      int ra, wa, idx;
      was_clear = (m_left > 0);
      was_done  = m_done;
      ra = int'(read_addr);
      wa = int'(write_addr);
      p2_v = s1_v;
      if (s1_v) begin p2_d = s1_d; p2_k = s1_k; end
      s1_v = re;
      if (re) begin
         if (ra >= DEPTH) begin s1_d = '0; s1_k = 1; end
         else begin s1_d = m_mem[ra]; s1_k = m_known[ra]; end
      end
      m_drop = we && (was_clear || wa >= DEPTH);
      if (we && !m_drop) begin m_mem[wa] = data_in; m_known[wa] = 1; end
      m_done = 0;
      if (was_clear) begin
         idx = DEPTH - m_left;
         m_mem[idx] = m_cval; m_known[idx] = 1;
         m_left--;
         if (m_left == 0) m_done = 1;
      end else if (!was_done && clr_req) begin
         m_left = DEPTH;
         m_cval = clr_value;
      end
   endtask

   task automatic compare_outputs();
      bit ev, ek;
      logic [DW-1:0] ed;
`ifdef FB_READ_REG_EN
      ev = p2_v; ed = p2_d; ek = p2_k;
`else
      ev = s1_v; ed = s1_d; ek = s1_k;
`endif
      check_eq("rd_valid", 32'(rd_valid), 32'(ev));
      if (ek) check_eq("data_out", 32'(data_out), 32'(ed));
      check_eq("clr_busy", 32'(clr_busy), 32'(m_left > 0));
      check_eq("clr_done", 32'(clr_done), 32'(m_done));
      check_eq("wr_drop",  32'(wr_drop),  32'(m_drop));
      busy_seen += int'(clr_busy);
      done_seen += int'(clr_done);
   endtask

   task automatic set_idle();
      we = 0; re = 0; clr_req = 0;
      write_addr = '0; read_addr = '0; data_in = '0; clr_value = '0;
   endtask

   task automatic cycle(input logic i_we, input logic [AW-1:0] i_wa, input logic [DW-1:0] i_wd,
                        input logic i_re, input logic [AW-1:0] i_ra,
                        input logic i_cr, input logic [DW-1:0] i_cv);
      @(negedge clk);
      we = i_we; write_addr = i_wa; data_in = i_wd;
      re = i_re; read_addr = i_ra;
      clr_req = i_cr; clr_value = i_cv;
      @(posedge clk);
      model_step();
      #1;
      compare_outputs();
      set_idle();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, 0, '0);
   endtask

   task automatic read_expect(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
      cycle(0, '0, '0, 1, a, 0, '0);
`ifdef FB_READ_REG_EN
      idle_cycles(1);
`endif
      check_eq(tag, 32'(data_out), 32'(e));
      check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_dout"},  32'(data_out), 32'd0);
      check_eq({tag, "_valid"}, 32'(rd_valid), 32'd0);
      check_eq({tag, "_busy"},  32'(clr_busy), 32'd0);
      check_eq({tag, "_done"},  32'(clr_done), 32'd0);
      check_eq({tag, "_drop"},  32'(wr_drop),  32'd0);
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1;
      #1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      set_idle();
      reset = 1'b0;
      do_reset();

      // Full clear with drops and a repeated request mid-clear
      busy_seen = 0; done_seen = 0;
      cycle(0, '0, '0, 0, '0, 1, 8'h10);
      for (int i = 0; i < DEPTH + 3; i++) begin
         cycle((i < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom_range(0, 255)),
               8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               (i == 50) ? 1'b1 : 1'b0, 8'h99);
      end
      check_eq("clr_busy_cycles", 32'(busy_seen), 32'(DEPTH));
      check_eq("clr_done_pulses", 32'(done_seen), 32'd1);
      read_expect("clr_rd_0",    8'd0,            8'h10);
      read_expect("clr_rd_100",  8'd100,          8'h10);
      read_expect("clr_rd_last", AW'(DEPTH - 1),  8'h10);

      // Write then read
      cycle(1, 8'd5, 8'hA5, 0, '0, 0, '0);
      read_expect("wr_rd_5", 8'd5, 8'hA5);

      // Read-first collision
      cycle(1, 8'd7, 8'h01, 0, '0, 0, '0);
      cycle(1, 8'd7, 8'h02, 1, 8'd7, 0, '0);
`ifdef FB_READ_REG_EN
      idle_cycles(1);
`endif
      check_eq("collide_old", 32'(data_out), 32'h01);
      read_expect("collide_new", 8'd7, 8'h02);

      // Out-of-range write and read
      cycle(1, AW'(DEPTH), 8'hAA, 0, '0, 0, '0);
      check_eq("oor_wr_drop", 32'(wr_drop), 32'd1);
      read_expect("oor_rd", AW'(DEPTH), 8'h00);
      read_expect("oor_keep_5", 8'd5, 8'hA5);

      // Write coinciding with clr_req is overwritten by the clear
      cycle(1, 8'd3, 8'h77, 0, '0, 1, 8'h5C);
      idle_cycles(DEPTH + 1);
      read_expect("wr_with_clr", 8'd3, 8'h5C);

      // Random traffic with occasional clears
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, 8'($urandom));
      end
      idle_cycles(DEPTH + 2);

      // Reset at cycle 100 of a clear
      cycle(0, '0, '0, 0, '0, 1, 8'h33);
      for (int i = 0; i < 100; i++) cycle(0, '0, '0, 1, 8'($urandom_range(0, 255)), 0, '0);
      check_eq("pre_rst_busy", 32'(clr_busy), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all_zero("rst_mid");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      idle_cycles(DEPTH + 10);
      check_eq("rst_mid_no_done", 32'(done_seen), 32'd0);
      cycle(0, '0, '0, 0, '0, 1, 8'h44);
      check_eq("rst_mid_restart", 32'(clr_busy), 32'd1);
      idle_cycles(DEPTH + 2);
      read_expect("restart_rd", 8'd9, 8'h44);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
